// File: rtl/lk_line_delay_ctrl_if.sv
// Pixel-stream, FIFO-control and pair-output bundle for the LK one-row line delay controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface lk_line_delay_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic                  start;
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_ready;

  logic                  fifo_flush;
  logic                  fifo_w_en;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_cur;
  logic [DATA_WIDTH-1:0] out_above;
  logic [XW-1:0]         out_x;
  logic [YW-1:0]         out_y;
  logic                  frame_done;
  logic                  busy;
  logic                  err_underflow;

  modport slave (
    input  start, pix_valid, pix_in, fifo_dout, fifo_full, fifo_empty,
    output pix_ready, fifo_flush, fifo_w_en, fifo_din, fifo_r_en,
    output out_valid, out_cur, out_above, out_x, out_y,
    output frame_done, busy, err_underflow
  );

  modport master (
    output start, pix_valid, pix_in, fifo_dout, fifo_full, fifo_empty,
    input  pix_ready, fifo_flush, fifo_w_en, fifo_din, fifo_r_en,
    input  out_valid, out_cur, out_above, out_x, out_y,
    input  frame_done, busy, err_underflow
  );
endinterface

// File: rtl/lk_line_delay_ctrl.sv
// Sequences an external sync FIFO as a one-row line delay: row 0 fills the FIFO, later rows
// pop the pixel above while pushing the current one, emitting (cur, above, x, y) one cycle later.
module lk_line_delay_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  lk_line_delay_ctrl_if.slave     ctrl_io
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  if ((IMG_W < 2) || (IMG_W > FIFO_DEPTH - 2) || (IMG_H < 2)) begin : g_bad_cfg
    $error("lk_line_delay_ctrl: IMG_W/IMG_H outside the range the FIFO depth supports");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  done_tail_q, done_tail_d;
  logic                  err_q, err_d;
  logic                  ovalid_q, ovalid_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] above_q, above_d;
  logic [XW-1:0]         ox_q, ox_d;
  logic [YW-1:0]         oy_q, oy_d;

  logic                  pix_ready_s;
  logic                  accept_s;
  logic                  w_en_s;
  logic                  r_en_s;

  assign pix_ready_s = (state_q == S_FILL) || (state_q == S_STREAM);
  assign accept_s    = ctrl_io.pix_valid && pix_ready_s;

  // Next-state, counter and FIFO-strobe logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    done_tail_d = 1'b0;
    err_d       = err_q;
    ovalid_d    = 1'b0;
    cur_d       = cur_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    w_en_s      = 1'b0;
    r_en_s      = 1'b0;
    // The FIFO read data is only valid in the cycle after a pop, so capture it then to hold it.
    if (ovalid_q) begin
      above_d = ctrl_io.fifo_dout;
    end else begin
      above_d = above_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_io.start) begin
          state_d = S_FLUSH;
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FLUSH: begin
        state_d = S_FILL;
      end

      S_FILL: begin
        if (accept_s) begin
          w_en_s = !ctrl_io.fifo_full;
          if (x_q == X_LAST) begin
            x_d     = '0;
            y_d     = Y_ONE;
            state_d = S_STREAM;
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          state_d = S_FILL;
        end
      end

      S_STREAM: begin
        if (accept_s) begin
          r_en_s   = 1'b1;
          w_en_s   = (y_q != Y_LAST) && !ctrl_io.fifo_full;
          ovalid_d = 1'b1;
          cur_d    = ctrl_io.pix_in;
          ox_d     = x_q;
          oy_d     = y_q;
          if (ctrl_io.fifo_empty) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          state_d = S_STREAM;
        end
      end

      S_DONE: begin
        // First DONE cycle carries the last pair; the second raises frame_done.
        if (done_tail_q) begin
          state_d = S_IDLE;
        end else begin
          done_tail_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output-pair registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      done_tail_q <= 1'b0;
      err_q       <= 1'b0;
      ovalid_q    <= 1'b0;
      cur_q       <= '0;
      above_q     <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      done_tail_q <= done_tail_d;
      err_q       <= err_d;
      ovalid_q    <= ovalid_d;
      cur_q       <= cur_d;
      above_q     <= above_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
    end
  end

  assign ctrl_io.pix_ready     = pix_ready_s;
  assign ctrl_io.fifo_flush    = (state_q == S_FLUSH);
  assign ctrl_io.fifo_w_en     = w_en_s;
  assign ctrl_io.fifo_din      = ctrl_io.pix_in;
  assign ctrl_io.fifo_r_en     = r_en_s;
  assign ctrl_io.out_valid     = ovalid_q;
  assign ctrl_io.out_cur       = cur_q;
  assign ctrl_io.out_above     = ovalid_q ? ctrl_io.fifo_dout : above_q;
  assign ctrl_io.out_x         = ox_q;
  assign ctrl_io.out_y         = oy_q;
  assign ctrl_io.frame_done    = (state_q == S_DONE) && done_tail_q;
  assign ctrl_io.busy          = (state_q != S_IDLE);
  assign ctrl_io.err_underflow = err_q;

endmodule

// File: tb/tb_lk_line_delay_ctrl.sv
// Directed bench for lk_line_delay_ctrl on a 4x3 frame with a behavioural 8-deep sync FIFO.
module tb_lk_line_delay_ctrl;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int NPIX = W * H;

  typedef struct {
    logic [DW-1:0] cur;
    logic [DW-1:0] above;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    int            cyc;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_empty = 1'b0;
  always #5 clk = ~clk;

  lk_line_delay_ctrl_if #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) bus ();
  lk_line_delay_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  // Behavioural sync FIFO, cleared by rst or fifo_flush, registered read data.
  logic [DW-1:0] mem [D];
  logic [2:0]    wp, rp;
  logic [3:0]    cnt;
  logic [DW-1:0] dout;
  wire           fifo_rst = rst | bus.fifo_flush;

  always @(posedge clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      wp <= 3'd0; rp <= 3'd0; cnt <= 4'd0; dout <= '0;
    end else begin
      if (bus.fifo_w_en && cnt < 4'(D - 1)) begin
        mem[wp] <= bus.fifo_din;
        wp <= wp + 3'd1;
      end
      if (bus.fifo_r_en && cnt != 4'd0) begin
        dout <= mem[rp];
        rp <= rp + 3'd1;
      end
      if ((bus.fifo_w_en && cnt < 4'(D - 1)) && !(bus.fifo_r_en && cnt != 4'd0)) cnt <= cnt + 4'd1;
      else if (!(bus.fifo_w_en && cnt < 4'(D - 1)) && (bus.fifo_r_en && cnt != 4'd0)) cnt <= cnt - 4'd1;
    end
  end

  assign bus.fifo_dout  = dout;
  assign bus.fifo_full  = (cnt == 4'(D - 1));
  assign bus.fifo_empty = (cnt == 4'd0) || force_empty;

  // Cycle counter and append-only event logs.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pair_t         pairs [$];
  logic [DW-1:0] wr_q [$];
  int            n_flush = 0, n_rd = 0, done_cnt = 0, done_cyc = 0;
  logic          done_empty = 1'b0, done_err = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_flush) n_flush = n_flush + 1;
      if (bus.fifo_w_en) wr_q.push_back(bus.fifo_din);
      if (bus.fifo_r_en) n_rd = n_rd + 1;
      if (bus.out_valid) pairs.push_back('{bus.out_cur, bus.out_above, bus.out_x, bus.out_y, cyc});
      if (bus.frame_done) begin
        done_cnt   = done_cnt + 1;
        done_cyc   = cyc;
        done_empty = bus.fifo_empty;
        done_err   = bus.err_underflow;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int p0, w0, f0, r0, d0;
  int in_cyc [NPIX];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = '0;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.pix_ready, bus.fifo_flush, bus.fifo_w_en, bus.fifo_r_en, bus.out_valid,
         bus.frame_done, bus.busy, bus.err_underflow} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got=%b%b%b%b%b%b%b%b exp=00000000", bus.pix_ready, bus.fifo_flush,
               bus.fifo_w_en, bus.fifo_r_en, bus.out_valid, bus.frame_done, bus.busy, bus.err_underflow);
    end
    checks++;
    if ({bus.out_cur, bus.out_above, bus.out_x, bus.out_y} !== '0) begin
      errors++;
      $display("FAIL reset_data got cur=%0d above=%0d x=%0d y=%0d exp all 0",
               bus.out_cur, bus.out_above, bus.out_x, bus.out_y);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b ready=%b exp 0 0", bus.busy, bus.pix_ready);
    end
    w0 = wr_q.size(); p0 = pairs.size();
    for (int i = 0; i < 5; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = DW'(8'h30 + i);
      tick();
    end
    bus.pix_valid = 1'b0;
    checks++;
    if (wr_q.size() != w0 || pairs.size() != p0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_pixels_ignored got writes=%0d pairs=%0d busy=%b exp 0 0 0",
               wr_q.size() - w0, pairs.size() - p0, bus.busy);
    end
  endtask

  task automatic start_frame();
    p0 = pairs.size(); w0 = wr_q.size(); f0 = n_flush; r0 = n_rd; d0 = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.fifo_flush !== 1'b1 || bus.busy !== 1'b1 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got flush=%b busy=%b ready=%b exp 1 1 0",
               bus.fifo_flush, bus.busy, bus.pix_ready);
    end
    checks++;
    if (bus.err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start got=%b exp=0", bus.err_underflow);
    end
    tick();
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.fifo_flush !== 1'b0) begin
      errors++;
      $display("FAIL fill_entry got ready=%b flush=%b exp 1 0", bus.pix_ready, bus.fifo_flush);
    end
  endtask

  task automatic drive_pixels(input logic [DW-1:0] base, input int n, input bit gap,
                              input bit force_first_read, input bit mid_start);
    for (int k = 0; k < n; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = DW'(base + k);
      force_empty   = force_first_read && (k == W);
      bus.start     = mid_start && (k == 6);
      in_cyc[k]     = cyc;
      tick();
      bus.start   = 1'b0;
      force_empty = 1'b0;
      if (gap) begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'hEE;
        tick();
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag, input logic [DW-1:0] base, input logic exp_err);
    int guard = 0;
    while (done_cnt == d0 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s frame_done_count got=%0d exp=1", tag, done_cnt - d0);
    end
    checks++;
    if (done_cyc != in_cyc[NPIX-1] + 2 || done_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done_timing got cyc=%0d empty=%b exp cyc=%0d empty=1",
               tag, done_cyc, done_empty, in_cyc[NPIX-1] + 2);
    end
    checks++;
    if (n_flush - f0 != 1 || n_rd - r0 != 2 * W) begin
      errors++;
      $display("FAIL %s strobe_counts got flush=%0d reads=%0d exp 1 %0d", tag, n_flush - f0, n_rd - r0, 2 * W);
    end
    checks++;
    if (wr_q.size() - w0 != 2 * W) begin
      errors++;
      $display("FAIL %s write_count got=%0d exp=%0d", tag, wr_q.size() - w0, 2 * W);
    end
    for (int i = 0; i < 2 * W; i++) begin
      if (w0 + i < wr_q.size()) begin
        checks++;
        if (wr_q[w0 + i] !== DW'(base + i)) begin
          errors++;
          $display("FAIL %s write_data[%0d] got=%0d exp=%0d", tag, i, wr_q[w0 + i], DW'(base + i));
        end
      end
    end
    checks++;
    if (pairs.size() - p0 != 2 * W) begin
      errors++;
      $display("FAIL %s pair_count got=%0d exp=%0d", tag, pairs.size() - p0, 2 * W);
    end
    for (int i = 0; i < 2 * W; i++) begin
      if (p0 + i < pairs.size()) begin
        pair_t pr;
        int k;
        pr = pairs[p0 + i];
        k  = i + W;
        checks++;
        if (pr.cur !== DW'(base + k) || pr.above !== DW'(base + i) || pr.x !== XW'(k % W) ||
            pr.y !== YW'(k / W) || pr.cyc != in_cyc[k] + 1) begin
          errors++;
          $display("FAIL %s pair[%0d] got (%0d,%0d) x=%0d y=%0d cyc=%0d exp (%0d,%0d) x=%0d y=%0d cyc=%0d",
                   tag, i, pr.cur, pr.above, pr.x, pr.y, pr.cyc,
                   DW'(base + k), DW'(base + i), k % W, k / W, in_cyc[k] + 1);
        end
      end
    end
    checks++;
    if (done_err !== exp_err || bus.err_underflow !== exp_err || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state got err_at_done=%b err=%b busy=%b exp %b %b 0",
               tag, done_err, bus.err_underflow, bus.busy, exp_err, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    start_frame();
    drive_pixels(8'd1, NPIX, 1'b0, 1'b0, 1'b0);
    finish_check("b2b", 8'd1, 1'b0);
  endtask

  task automatic test_gapped();
    start_frame();
    drive_pixels(8'd1, NPIX, 1'b1, 1'b0, 1'b0);
    finish_check("gapped", 8'd1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    drive_pixels(8'd1, 6, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL async_abort got busy=%b ready=%b oval=%b r_en=%b exp 0 0 0 0",
               bus.busy, bus.pix_ready, bus.out_valid, bus.fifo_r_en);
    end
    tick();
    rst = 1'b0;
    tick();
    start_frame();
    drive_pixels(8'd101, NPIX, 1'b0, 1'b0, 1'b0);
    finish_check("after_abort", 8'd101, 1'b0);
  endtask

  task automatic test_underflow();
    start_frame();
    drive_pixels(8'd1, NPIX, 1'b0, 1'b1, 1'b0);
    finish_check("underflow", 8'd1, 1'b1);
    tick();
    checks++;
    if (bus.err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky_in_idle got=%b exp=1", bus.err_underflow);
    end
  endtask

  task automatic test_start_in_stream();
    start_frame();
    drive_pixels(8'd50, NPIX, 1'b0, 1'b0, 1'b1);
    finish_check("start_in_stream", 8'd50, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    test_underflow();
    test_start_in_stream();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lk_line_delay_ctrl.md
Name: lk_line_delay_ctrl

Overview:
- Controller that sequences one sync FIFO instance as a one-row line delay for the pyramidal LK gradient stage.
- Accepts a raster-order pixel stream for one frame level and writes each row into the FIFO.
- Pops the previous row in lockstep, so every pixel from row 1 onward is emitted paired with the pixel directly above it (vertical gradient input).
- Owns all FIFO control (flush, w_en, r_en) and reports frame completion and underflow errors.

Parameters:
DATA_WIDTH, 8, pixel width; must match the FIFO DATA_WIDTH
IMG_W, 640, pixels per row; legal range 2 ≤ IMG_W ≤ FIFO_DEPTH-2
IMG_H, 480, rows per frame; minimum 2
FIFO_DEPTH, 2048, depth of the attached FIFO; usable capacity is FIFO_DEPTH-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE
pix_valid  in  1  input pixel strobe
pix_in  in  DATA_WIDTH  input pixel, raster order
pix_ready  out  1  high in FILL and STREAM; pix_valid while low is ignored
fifo_flush  out  1  one-cycle pulse, OR'd into the FIFO rst
fifo_w_en  out  1  FIFO write enable (combinational)
fifo_din  out  DATA_WIDTH  FIFO write data, equal to pix_in
fifo_r_en  out  1  FIFO read enable (combinational)
fifo_dout  in  DATA_WIDTH  FIFO registered read data
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
out_valid  out  1  output pair strobe
out_cur  out  DATA_WIDTH  current-row pixel
out_above  out  DATA_WIDTH  pixel at the same x in the previous row
out_x  out  $clog2(IMG_W)  column of the output pair
out_y  out  $clog2(IMG_H)  row of the output pair (≥1)
frame_done  out  1  one-cycle pulse after the last pair
busy  out  1  high whenever state ≠ IDLE
err_underflow  out  1  sticky; cleared by rst or start

Behaviour:
- Reset: state IDLE; x/y counters 0; all outputs 0, including pix_ready, out_*, frame_done, err_underflow and fifo_flush.
- Reset mid-frame aborts immediately. The FIFO shares rst, so the FIFO is also cleared.
- FSM states: IDLE, FLUSH, FILL, STREAM, DONE.
- IDLE:
  - start → FLUSH.
  - Clear x, y and err_underflow.
- FLUSH:
  - fifo_flush=1 for exactly one cycle, clearing stale FIFO entries from an aborted frame.
  - pix_ready=0.
  - Next state is FILL.
- FILL (row 0):
  - On each accepted pixel: fifo_w_en=1 and x++.
  - No reads and no output.
  - When x==IMG_W-1 is accepted: x←0, y←1, go to STREAM.
- STREAM (rows 1..IMG_H-1), per accepted pixel:
  - fifo_r_en=1.
  - fifo_w_en=1 except when y==IMG_H-1. The last row is not buffered, so the FIFO ends the frame empty.
  - Read and write happen in the same cycle, so occupancy stays IMG_W. IMG_W ≤ FIFO_DEPTH-2 guarantees !fifo_full at the write.
  - pix_in, x and y are registered in a one-stage delay.
- Output latency: exactly 1 cycle.
  - The cycle after an accepted STREAM pixel: out_valid=1, out_cur=delayed pix_in, out_above=fifo_dout, out_x/out_y=delayed counters.
  - out_valid is 0 on all other cycles; out_* hold their last values.
- Counters:
  - x wraps IMG_W-1→0 and increments y.
  - After accepting (IMG_W-1, IMG_H-1), go to DONE.
- DONE:
  - The final out_valid occurs in the first DONE cycle.
  - frame_done=1 in the following cycle, with fifo_empty expected 1.
  - Then return to IDLE.
- Underflow: a STREAM read with fifo_empty=1 sets err_underflow. out_valid is still issued, with out_above=fifo_dout as-is.
- Input gaps: pix_valid may drop for any number of cycles in FILL or STREAM. State and counters hold; no FIFO strobes are issued.
- start in any non-IDLE state is ignored. pix_valid in IDLE, FLUSH or DONE is ignored; no FIFO strobes are issued.
- A start pulse in the same cycle as the frame_done cycle is ignored (state is DONE).

Test Plan (IMG_W=4, IMG_H=3, FIFO_DEPTH=8, DATA_WIDTH=8):
- Reset then idle: all outputs 0, busy=0. Pixels with pix_valid=1 and no start → no fifo_w_en, no out_valid.
- start, then 12 back-to-back pixels 1..12 →
  - fifo_flush pulses once.
  - Pixels 1–4 are written, no output.
  - out pairs (cur, above), each 1 cycle after input: (5,1)(6,2)(7,3)(8,4)@y=1 and (9,5)(10,6)(11,7)(12,8)@y=2.
  - fifo_w_en is low for pixels 9–12.
  - frame_done pulses 2 cycles after pixel 12; fifo_empty=1 at frame_done.
- Same frame with pix_valid toggling 1/0 every cycle → identical pair sequence; out_valid is spaced every 2 cycles; no extra FIFO strobes.
- Reset asserted after pixel 6, then a new start with pixels 101..112 →
  - state returns to IDLE immediately on reset.
  - New-frame first pair is (105,101); no stale data appears.
- Force fifo_empty=1 during the first STREAM read → err_underflow=1 and stays 1 through frame_done. The next start clears it.
- start pulsed during STREAM → ignored; counters and output sequence are unchanged.
